dram_req_queue: RTL
===================

Name: dram_req_queue

Overview:
- Request queue and issue sequencer directly upstream of dram_controller.
- Accepts burst-sized read/write requests from a user port through a valid/ready handshake and buffers them in a FIFO of depth DEPTH.
- Issues them one at a time on the controller's read/write/address/write_data/ack/busy interface.
- Returns read data with the request's tag.

Parameters:
- ADDR_W, 26, request address width; matches controller address width ROW_BITS+COL_BITS+BA_BITS.
- DATA_W, 128, burst data width; matches BL_MAX*DQ_BITS.
- TAG_W, 4, user tag width, echoed on read responses.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  controller clock (same clock as dram_controller).
- rst_n_i  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept; equals !full.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  burst address.
- req_wdata  in  DATA_W  write burst data; ignored for reads.
- req_tag  in  TAG_W  request tag.
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_data  out  DATA_W  read burst data.
- rsp_tag  out  TAG_W  tag of the completed read.
- ctrl_read  out  1  read command to controller.
- ctrl_write  out  1  write command to controller.
- ctrl_address  out  ADDR_W  command address.
- ctrl_write_data  out  DATA_W  command write data.
- ctrl_read_data  in  DATA_W  controller read data; valid with ctrl_ack.
- ctrl_ack  in  1  controller completion pulse.
- ctrl_busy  in  1  controller busy (initialising or executing).
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky timeout flag; constant 0 without the optional feature.

Behaviour:
- Reset, asynchronous on rst_n_i low:
  - FIFO pointers and count cleared.
  - State returns to IDLE.
  - ctrl_read, ctrl_write, rsp_valid and err go to 0.
  - ctrl_address, ctrl_write_data, rsp_data and rsp_tag go to 0.
  - Reset asserted mid-command drops the command immediately; no response is produced.
- Push: an entry {we, addr, wdata, tag} is written when req_valid && req_ready on a rising edge of clk_i.
- req_ready is combinational !full.
- When full, a pop in the same cycle does not open a slot for a push; req_ready stays 0 that cycle.
- Pop: the head entry is removed on the cycle ctrl_ack is sampled high in ISSUE.
- level is updated every cycle. A simultaneous push and pop leaves level unchanged. Wrap-around uses DEPTH-modulo pointers.
- FSM:
  - IDLE: if not empty and ctrl_busy==0, load ctrl_address, ctrl_write_data and the head type/tag into registers. Set ctrl_write=we or ctrl_read=!we. Go to ISSUE. Otherwise stay.
  - ISSUE: hold the command outputs stable until ctrl_ack==1. On ack:
    - deassert ctrl_read/ctrl_write on the next edge;
    - pop the head;
    - for a read, register ctrl_read_data into rsp_data and the tag into rsp_tag, and pulse rsp_valid for exactly one cycle (1 cycle after ack);
    - go to WAIT.
  - WAIT: stay until ctrl_busy==0, then go to IDLE. This guarantees at least one idle cycle between commands.
- Never more than one outstanding command.
- ctrl_read and ctrl_write are never both 1.
- Writes produce no response.
- Latency, empty queue with controller idle: command issued 1 cycle after the push edge.
- ctrl_ack outside ISSUE is ignored.

Optional Feature:
- Macro DRAM_REQ_QUEUE_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE. On reaching TIMEOUT_CYCLES without ack: set err (sticky until reset), deassert the command, pop the head, go to WAIT.
  - No rsp_valid is produced for the aborted read.
- Undefined: no counter; ISSUE waits indefinitely; err is tied to 0.

Test Plan:
1. Release reset while ctrl_busy=1 and push write addr=0x0001234, wdata=0xA5…A5 -> no ctrl_write until busy falls. Then ctrl_write=1 with address 0x0001234 held until ack. level goes 1→0 on the ack cycle. No rsp_valid.
2. Write addr 0x10 data D, then read addr 0x10 tag 0x7, with a bench controller model returning D -> exactly one rsp_valid pulse, rsp_tag=0x7, rsp_data=D, one cycle after the read ack.
3. Hold ctrl_busy=1 and push 4 requests -> req_ready=0 and level=4. A 5th req_valid is not accepted. After release, all 4 issue in FIFO order, each preceded by busy low.
4. Full queue, present req_valid on the same cycle as ack -> push rejected that cycle, accepted next cycle. level 4→3→4.
5. Assert rst_n_i low for 1 ns mid-ISSUE -> ctrl_read/ctrl_write go to 0 immediately, level=0, no rsp_valid after reset.
6. With DRAM_REQ_QUEUE_TIMEOUT_EN, TIMEOUT_CYCLES=16, and a read never acked -> err=1 after 16 cycles in ISSUE, command dropped, next queued request issues normally. Without the macro, the command is held indefinitely and err=0.

Source files
------------

// File: rtl/dram_req_queue.sv
// dram_req_queue: request FIFO and one-at-a-time issue sequencer for dram_controller.
// Define DRAM_REQ_QUEUE_TIMEOUT_EN to abort commands left unacknowledged for TIMEOUT_CYCLES.
module dram_req_queue #(
    parameter int ADDR_W         = 26,
    parameter int DATA_W         = 128,
    parameter int TAG_W          = 4,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     ctrl_read,
    output logic                     ctrl_write,
    output logic [ADDR_W-1:0]        ctrl_address,
    output logic [DATA_W-1:0]        ctrl_write_data,
    input  logic [DATA_W-1:0]        ctrl_read_data,
    input  logic                     ctrl_ack,
    input  logic                     ctrl_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DEPTH-1:0]  we_mem;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic              cur_we_q;
    logic [TAG_W-1:0]  cur_tag_q;
    logic              full, empty, push, pop, abort;

    assign full      = (cnt_q == LVL_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign req_ready = !full;
    assign level     = cnt_q;

    always_comb begin
        push     = req_valid && !full;
        pop      = (state_q == ISSUE) && (ctrl_ack || abort);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= req_addr;
            data_mem[wr_ptr_q] <= req_wdata;
            tag_mem[wr_ptr_q]  <= req_tag;
            we_mem[wr_ptr_q]   <= req_we;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head stays in the FIFO until completion so level reflects the in-flight command.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            ctrl_read       <= 1'b0;
            ctrl_write      <= 1'b0;
            ctrl_address    <= '0;
            ctrl_write_data <= '0;
            cur_we_q        <= 1'b0;
            cur_tag_q       <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_tag         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!empty && !ctrl_busy) begin
                        ctrl_address    <= addr_mem[rd_ptr_q];
                        ctrl_write_data <= data_mem[rd_ptr_q];
                        cur_we_q        <= we_mem[rd_ptr_q];
                        cur_tag_q       <= tag_mem[rd_ptr_q];
                        ctrl_write      <= we_mem[rd_ptr_q];
                        ctrl_read       <= !we_mem[rd_ptr_q];
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (pop) begin
                        ctrl_read  <= 1'b0;
                        ctrl_write <= 1'b0;
                        state_q    <= WAIT;
                        if (ctrl_ack && !cur_we_q) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= ctrl_read_data;
                            rsp_tag   <= cur_tag_q;
                        end
                    end
                end
                WAIT: begin
                    if (!ctrl_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DRAM_REQ_QUEUE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign abort = (state_q == ISSUE) && !ctrl_ack &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err   = err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE) tmo_q <= tmo_q + TMO_W'(1);
            else                  tmo_q <= '0;
            if (abort) err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign abort      = 1'b0;
    assign err        = 1'b0;
`endif

endmodule
